// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL RESET, filters the asynchronous lock and
// sequences a stretched system reset, re-arming the PLL on timeout or loss.
module pll_lock_supervisor #(
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned HOLD_CYCLES    = 256,
    parameter int unsigned LOCK_TIMEOUT   = 1048576,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic             sys_rst,
    output logic             ready,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int unsigned MAX_A = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int unsigned MAX_B = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_T);

    localparam logic [CW-1:0]    FILT_END = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0]    HOLD_END = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]    TO_END   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    PRST_END = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT      = {CNT_W{1'b1}};

    // Thresholds below 2 would make the exact-equality compares degenerate
    if (LOCK_FILTER < 2 || HOLD_CYCLES < 2 || LOCK_TIMEOUT < 2 ||
        PLL_RST_CYCLES < 2 || CNT_W < 2) begin : g_param_check
        $error("pll_lock_supervisor: all parameters must be >= 2");
    end

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sync1, lock_s;
    logic          loss_inc, to_inc;

    // Next-state and shared counter decode
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        loss_inc = 1'b0;
        to_inc   = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == PRST_END) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = FILTER;
                    cnt_n   = '0;
                end else if (cnt == TO_END) begin
                    state_n = PLL_RST;
                    cnt_n   = '0;
                    to_inc  = 1'b1;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == FILT_END) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == HOLD_END) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lock_s) begin
                    state_n  = PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_n = PLL_RST;
                cnt_n   = '0;
            end
        endcase
    end

    // State, synchroniser, counters and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b0;
            lock_s      <= 1'b0;
            state       <= PLL_RST;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            loss_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            sync1     <= pll_lock;
            lock_s    <= sync1;
            state     <= state_n;
            cnt       <= cnt_n;
            pll_reset <= (state_n == PLL_RST);
            sys_rst   <= (state_n != RUN);
            ready     <= (state_n == RUN);
            if (loss_inc && loss_cnt != SAT) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
            if (to_inc && timeout_cnt != SAT) begin
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises the board's 27 MHz rPLL from the free-running oscillator domain.
- Drives the PLL RESET input and synchronises and debounces the asynchronous PLL lock.
- Issues a stretched system reset once lock is stable, and re-arms the PLL when lock times out or is lost.
- Counts lock-loss events for debug readout.

Parameters:
- LOCK_FILTER, 1024: consecutive synchronised lock-high cycles before lock counts as stable.
- HOLD_CYCLES, 256: cycles `sys_rst` stays asserted after stable lock.
- LOCK_TIMEOUT, 1048576: cycles allowed in WAIT_LOCK before the PLL is re-reset.
- PLL_RST_CYCLES, 16: width of the `pll_reset` pulse in cycles.
- CNT_W, 8: width of `loss_cnt`.

Ports:
- clk  input  1  27 MHz oscillator clock, also the PLL reference.
- reset  input  1  synchronous, active-high block reset.
- pll_lock  input  1  PLL LOCK output, asynchronous to `clk`.
- pll_reset  output  1  drives PLL RESET, active-high.
- sys_rst  output  1  active-high system reset, synchronous to `clk`; consumers in other domains re-synchronise it.
- ready  output  1  high in RUN.
- state_o  output  3  current state encoding, for debug.
- loss_cnt  output  CNT_W  saturating count of lock losses seen in RUN.
- timeout_cnt  output  CNT_W  saturating count of LOCK_TIMEOUT expiries.

Behaviour:
- Clock and reset:
  - One clock, `clk`; `reset` is synchronous and active-high.
  - `pll_lock` passes through a 2-FF synchroniser (`lock_s`) before any use; 2 cycles of latency.
- Values while `reset` is high and on the first cycle after it:
  - state = PLL_RST; `pll_reset` = 1; `sys_rst` = 1; `ready` = 0.
  - `loss_cnt` = 0; `timeout_cnt` = 0; all internal counters = 0; synchroniser flops = 0.
- States and encodings: PLL_RST=0, WAIT_LOCK=1, FILTER=2, HOLD=3, RUN=4.
- PLL_RST:
  - `pll_reset` = 1 and `sys_rst` = 1.
  - Counts PLL_RST_CYCLES cycles, then moves to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - `pll_reset` = 0 and `sys_rst` = 1; a timeout counter increments every cycle.
  - `lock_s` = 1: go to FILTER, clear the counter.
  - Counter reaches LOCK_TIMEOUT-1 with `lock_s` still 0: increment `timeout_cnt` (saturating) and go to PLL_RST.
  - If `lock_s` rises on the same cycle as the timeout, the lock wins and the state goes to FILTER.
- FILTER:
  - `sys_rst` = 1; the counter increments while `lock_s` = 1.
  - `lock_s` = 0 clears the counter and returns to WAIT_LOCK; the timeout restarts from 0 and `timeout_cnt` is unchanged.
  - Counter reaches LOCK_FILTER-1 with `lock_s` = 1: go to HOLD.
- HOLD:
  - `sys_rst` = 1; counts HOLD_CYCLES cycles, then goes to RUN.
  - `lock_s` = 0 during HOLD returns to WAIT_LOCK; this is not counted as a loss.
- RUN:
  - `sys_rst` = 0 and `ready` = 1.
  - `lock_s` = 0 for 1 cycle: increment `loss_cnt` (saturating), go to PLL_RST.
  - `sys_rst` and `ready` change on the same registered edge as the state change.
- Outputs: all are registered, with no combinational path from `pll_lock`.
- Latency: from `pll_lock` rising (with `clk` running and the state in WAIT_LOCK) to `sys_rst` falling is 2 + 1 + LOCK_FILTER + HOLD_CYCLES cycles, ±1 for synchroniser phase.
- Counters:
  - Internal counter width is `$clog2` of the largest threshold.
  - Comparisons are exact-equality against threshold-1.
  - Parameters must be ≥ 2; elaboration fails otherwise.
- Saturation: `loss_cnt` and `timeout_cnt` stop at 2^CNT_W-1 and never wrap.
- Reset mid-operation: `reset` asserted in any state returns to the reset values on the next edge, including clearing the saturating counters.
- Glitches: a `pll_lock` pulse shorter than 1 cycle may be missed; that is acceptable. Any lock drop seen in RUN always forces a full PLL re-reset.

Test Plan (bench uses LOCK_FILTER=8, HOLD_CYCLES=4, LOCK_TIMEOUT=32, PLL_RST_CYCLES=3, CNT_W=4):
1. Release `reset`, raise `pll_lock` 5 cycles later and hold it -> `pll_reset` high for exactly 3 cycles; `sys_rst` falls and `ready` rises 2+1+8+4 cycles after lock is sampled; `loss_cnt` = 0.
2. Hold `pll_lock` = 0 after `reset` -> `pll_reset` re-pulses every 3+32 cycles; `timeout_cnt` = 1, 2, 3 after each expiry; `sys_rst` stays 1.
3. Drop `pll_lock` for 1 cycle on filter cycle 5 -> state returns to WAIT_LOCK; `sys_rst` stays 1; `loss_cnt` = 0; filter restarts and needs a full 8 cycles.
4. In RUN, drop `pll_lock` for 2 cycles -> `sys_rst` = 1 and `ready` = 0 exactly 3 cycles after the drop (2 sync + 1); `loss_cnt` = 1; `pll_reset` pulses 3 cycles; the system recovers to RUN after relock.
5. Force 20 lock losses in RUN -> `loss_cnt` saturates at 15 and does not wrap to 0.
6. Assert `reset` for 1 cycle while in HOLD, and again while in RUN -> state = PLL_RST, `sys_rst` = 1, `pll_reset` = 1, both counts = 0 on the next cycle.
